// File: rtl/serial_rx_controller.sv
// serial_rx_controller
// Receive-side frame sequencer for a single-wire serial line. It finds the
// start bit and samples WIDTH data bits (LSB first) at bit-centre into a
// right-shift capture register, then checks the stop bit. A finished word is
// handed to a one-deep holding register with a valid/ready handshake.
// frame_err and overrun are one-cycle registered pulses.
module serial_rx_controller #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  // HALF is the offset from a bit boundary to its centre sample.
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  // With HALF=0 the start-bit sample coincides with the IDLE detection cycle.
  localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             word_done_s;

  // Right shift with the new sample entering the MSB; safe for WIDTH=1.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic bit_in);
    logic [WIDTH-1:0] res;
    res = cur >> 1;
    res[WIDTH-1] = bit_in;
    return res;
  endfunction

  // Frame sequencing: next state, bit-period counter, bit index and capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    word_done_s = 1'b0;
    frame_err_d = 1'b0;
    if (!enable) begin
      // Disabled: abandon any partial frame without raising flags.
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      idx_d   = IDX_ZERO;
      shreg_d = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!serial_in) begin
            cnt_d = CNT_ZERO;
            idx_d = IDX_ZERO;
            if (HALF == 0) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_START;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = CNT_ZERO;
            if (!serial_in) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = CNT_ZERO;
            shreg_d = shift_in(shreg_q, serial_in);
            if (idx_q == IDX_LAST) begin
              idx_d   = IDX_ZERO;
              state_d = ST_STOP;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = CNT_ZERO;
            if (serial_in) begin
              word_done_s = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          // A stuck-low line must not be mistaken for a new start bit.
          if (serial_in) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_HIGH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          idx_d   = IDX_ZERO;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Holding register and handshake; a word arriving while full is dropped.
  always_comb begin
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    overrun_d   = 1'b0;
    if (word_done_s) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        data_out_d  = shreg_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, counters and all output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      idx_q       <= IDX_ZERO;
      shreg_q     <= {WIDTH{1'b0}};
      data_out_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_rx_controller.sv
// Bench for serial_rx_controller. Two instances (CLKS_PER_BIT=1 and 4) share
// one stimulus stream; a frame-level reference model predicts every output of
// each instance per cycle from sample-point arithmetic on the line waveform.
// Packed observation format: {valid, data[3:0], busy, frame_err, overrun}.
module tb_serial_rx_controller;

  localparam int W    = 4;
  localparam int MAXL = 256;

  logic clk = 1'b0;
  logic reset_n, enable, serial_in, out_ready;
  logic [W-1:0] d1_data, d4_data;
  logic d1_valid, d1_busy, d1_fe, d1_ov;
  logic d4_valid, d4_busy, d4_fe, d4_ov;

  int vecs = 0;
  int miscompares = 0;

  logic s_line [MAXL];
  logic s_en   [MAXL];
  logic s_rdy  [MAXL];
  int   len;
  logic [7:0] got_pk [2][MAXL];
  logic [7:0] exp_pk [2][MAXL];

  always #5 clk = ~clk;

  serial_rx_controller #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .serial_in(serial_in),
    .data_out(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .busy(d1_busy), .frame_err(d1_fe), .overrun(d1_ov));

  serial_rx_controller #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .serial_in(serial_in),
    .data_out(d4_data), .out_valid(d4_valid), .out_ready(out_ready),
    .busy(d4_busy), .frame_err(d4_fe), .overrun(d4_ov));

  task automatic clear_stim(input int l);
    len = l;
    for (int i = 0; i < MAXL; i++) begin
      s_line[i] = 1'b1;
      s_en[i]   = 1'b1;
      s_rdy[i]  = 1'b0;
    end
  endtask

  task automatic put_frame(input int t0, input int n, input logic [3:0] w, input logic stop_ok);
    logic b;
    for (int k = 0; k <= W + 1; k++) begin
      if (k == 0) b = 1'b0;
      else if (k == W + 1) b = stop_ok;
      else b = w[k-1];
      for (int j = 0; j < n; j++)
        if (t0 + k * n + j < MAXL) s_line[t0 + k * n + j] = b;
    end
  endtask

  // Apply the stimulus arrays one cycle at a time, recording outputs first.
  task automatic run_window(input logic do_reset);
    @(negedge clk);
    if (do_reset) begin
      reset_n = 1'b0; serial_in = 1'b1; enable = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
    end
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      got_pk[0][c] = {d1_valid, d1_data, d1_busy, d1_fe, d1_ov};
      got_pk[1][c] = {d4_valid, d4_data, d4_busy, d4_fe, d4_ov};
      serial_in = s_line[c];
      enable    = s_en[c];
      out_ready = s_rdy[c];
    end
  endtask

  // Frame-level reference: locate start edges, read the line at bit-centre
  // points t0 + k*n + half, then play completions through the holding register.
  task automatic model(input int di, input int n);
    int half, free_c, t0, end_c, oc, s, chk, x;
    logic [3:0] w, d;
    logic v;
    logic busy_a [MAXL+2];
    logic fe_a   [MAXL+2];
    logic ov_a   [MAXL+2];
    logic comp_a [MAXL+2];
    logic [3:0] word_a [MAXL+2];
    half = (n - 1) / 2;
    free_c = 0;
    for (int i = 0; i < MAXL + 2; i++) begin
      busy_a[i] = 1'b0; fe_a[i] = 1'b0; ov_a[i] = 1'b0; comp_a[i] = 1'b0; word_a[i] = 4'h0;
    end
    for (int c = 0; c < len; c++) begin
      if (c >= free_c && s_en[c] && s_line[c] == 1'b0) begin
        t0 = c; end_c = -1; oc = 0; chk = t0 + 1; w = 4'h0;
        for (int k = 0; k <= W + 1 && end_c < 0; k++) begin
          s = t0 + k * n + half;
          if (s >= len) s = len - 1;
          for (x = chk; x <= s && end_c < 0; x++)
            if (!s_en[x]) end_c = x;
          chk = s + 1;
          if (end_c < 0) begin
            if (k == 0) begin
              if (s_line[s]) end_c = s;
            end else if (k <= W) begin
              w[k-1] = s_line[s];
            end else begin
              end_c = s;
              oc = s_line[s] ? 1 : 2;
            end
          end
        end
        if (oc == 2) begin
          fe_a[end_c + 1] = 1'b1;
          x = end_c + 1;
          while (x < len && s_en[x] && !s_line[x]) x++;
          if (x >= len) x = len - 1;
          end_c = x;
        end else if (oc == 1) begin
          comp_a[end_c] = 1'b1;
          word_a[end_c] = w;
        end
        for (x = t0 + 1; x <= end_c; x++) busy_a[x] = 1'b1;
        free_c = end_c + 1;
      end
    end
    v = 1'b0; d = 4'h0;
    for (int c = 0; c < len; c++) begin
      exp_pk[di][c] = {v, d, busy_a[c], fe_a[c], ov_a[c]};
      if (comp_a[c]) begin
        if (!v || s_rdy[c]) begin
          v = 1'b1; d = word_a[c];
        end else begin
          ov_a[c + 1] = 1'b1;
        end
      end else if (v && s_rdy[c]) begin
        v = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; serial_in = 1'b1; enable = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({d1_valid, d1_data, d1_busy, d1_fe, d1_ov, d4_valid, d4_data, d4_busy, d4_fe, d4_ov} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_values: got %b/%b want all zero",
               {d1_valid, d1_data, d1_busy, d1_fe, d1_ov}, {d4_valid, d4_data, d4_busy, d4_fe, d4_ov});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_frame_n1();
    clear_stim(40);
    put_frame(0, 1, 4'hD, 1'b1);
    run_window(1'b1);
    model(0, 1); model(1, 4);
    for (int di = 0; di < 2; di++)
      for (int c = 0; c < len; c++) begin
        vecs++;
        if (got_pk[di][c] !== exp_pk[di][c]) begin
          miscompares++;
          $display("FAIL frame_n1 dut%0d cycle %0d: got %b want %b", di, c, got_pk[di][c], exp_pk[di][c]);
        end
      end
    for (int c = 0; c < 8; c++) begin
      vecs++;
      if (got_pk[0][c][2] !== ((c >= 1 && c <= 5) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL n1_busy cycle %0d: got %b", c, got_pk[0][c][2]);
      end
    end
    vecs++;
    if (got_pk[0][6][7:3] !== 5'b1_1101 || got_pk[0][5][7] !== 1'b0 || got_pk[0][6][1] !== 1'b0) begin
      miscompares++;
      $display("FAIL n1_word: got cycle5 %b cycle6 %b want valid at 6 with data d", got_pk[0][5], got_pk[0][6]);
    end
  endtask

  task automatic test_frame_n4();
    clear_stim(50);
    put_frame(0, 4, 4'hD, 1'b1);
    run_window(1'b1);
    model(0, 1); model(1, 4);
    for (int di = 0; di < 2; di++)
      for (int c = 0; c < len; c++) begin
        vecs++;
        if (got_pk[di][c] !== exp_pk[di][c]) begin
          miscompares++;
          $display("FAIL frame_n4 dut%0d cycle %0d: got %b want %b", di, c, got_pk[di][c], exp_pk[di][c]);
        end
      end
    vecs++;
    if (got_pk[1][22][7:3] !== 5'b1_1101 || got_pk[1][21][7] !== 1'b0) begin
      miscompares++;
      $display("FAIL n4_word: got cycle21 %b cycle22 %b want valid data d at 22", got_pk[1][21], got_pk[1][22]);
    end
  endtask

  task automatic test_false_start();
    clear_stim(30);
    s_line[2] = 1'b0;
    run_window(1'b1);
    model(0, 1); model(1, 4);
    for (int di = 0; di < 2; di++)
      for (int c = 0; c < len; c++) begin
        vecs++;
        if (got_pk[di][c] !== exp_pk[di][c]) begin
          miscompares++;
          $display("FAIL false_start dut%0d cycle %0d: got %b want %b", di, c, got_pk[di][c], exp_pk[di][c]);
        end
      end
    for (int c = 0; c < len; c++) begin
      vecs++;
      if (got_pk[1][c] !== ((c == 3) ? 8'b0000_0100 : 8'b0000_0000)) begin
        miscompares++;
        $display("FAIL false_start_n4 cycle %0d: got %b", c, got_pk[1][c]);
      end
    end
  endtask

  task automatic test_frame_err();
    clear_stim(30);
    for (int c = 0; c < 9; c++) s_line[c] = 1'b0;
    run_window(1'b1);
    model(0, 1); model(1, 4);
    for (int di = 0; di < 2; di++)
      for (int c = 0; c < len; c++) begin
        vecs++;
        if (got_pk[di][c] !== exp_pk[di][c]) begin
          miscompares++;
          $display("FAIL frame_err dut%0d cycle %0d: got %b want %b", di, c, got_pk[di][c], exp_pk[di][c]);
        end
      end
    for (int c = 0; c < 12; c++) begin
      vecs++;
      if (got_pk[0][c] !== {5'b0, (c >= 1 && c <= 9) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL frame_err_n1 cycle %0d: got %b", c, got_pk[0][c]);
      end
    end
  endtask

  task automatic test_overrun();
    for (int pass = 0; pass < 2; pass++) begin
      clear_stim(30);
      put_frame(0, 1, 4'h3, 1'b1);
      put_frame(6, 1, 4'hA, 1'b1);
      if (pass == 1) s_rdy[11] = 1'b1;
      run_window(1'b1);
      model(0, 1); model(1, 4);
      for (int di = 0; di < 2; di++)
        for (int c = 0; c < len; c++) begin
          vecs++;
          if (got_pk[di][c] !== exp_pk[di][c]) begin
            miscompares++;
            $display("FAIL overrun%0d dut%0d cycle %0d: got %b want %b", pass, di, c, got_pk[di][c], exp_pk[di][c]);
          end
        end
      vecs++;
      if (got_pk[0][12] !== ((pass == 0) ? 8'b1_0011_001 : 8'b1_1010_000)) begin
        miscompares++;
        $display("FAIL overrun%0d_n1 cycle 12: got %b", pass, got_pk[0][12]);
      end
    end
  endtask

  task automatic test_enable_abort();
    clear_stim(70);
    put_frame(0, 4, 4'h9, 1'b1);
    for (int c = 11; c < 30; c++) s_line[c] = 1'b1;
    s_en[10] = 1'b0;
    put_frame(30, 4, 4'h6, 1'b1);
    run_window(1'b1);
    model(0, 1); model(1, 4);
    for (int di = 0; di < 2; di++)
      for (int c = 0; c < len; c++) begin
        vecs++;
        if (got_pk[di][c] !== exp_pk[di][c]) begin
          miscompares++;
          $display("FAIL enable_abort dut%0d cycle %0d: got %b want %b", di, c, got_pk[di][c], exp_pk[di][c]);
        end
      end
    vecs++;
    if (got_pk[1][10][2] !== 1'b1 || got_pk[1][11][2] !== 1'b0 || got_pk[1][51][7] !== 1'b0
        || got_pk[1][52][7:3] !== 5'b1_0110) begin
      miscompares++;
      $display("FAIL enable_abort_n4: got c10 %b c11 %b c51 %b c52 %b",
               got_pk[1][10], got_pk[1][11], got_pk[1][51], got_pk[1][52]);
    end
  endtask

  task automatic test_reset_mid();
    clear_stim(30);
    put_frame(0, 4, 4'h6, 1'b1);
    run_window(1'b1);
    @(negedge clk);
    serial_in = 1'b0; enable = 1'b1;
    repeat (6) @(negedge clk);
    vecs++;
    if (d4_busy !== 1'b1 || d4_valid !== 1'b1 || d4_data !== 4'h6) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got busy %b valid %b data %h want 1 1 6", d4_busy, d4_valid, d4_data);
    end
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if ({d1_valid, d1_data, d1_busy, d1_fe, d1_ov, d4_valid, d4_data, d4_busy, d4_fe, d4_ov} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %b/%b want all zero",
               {d1_valid, d1_data, d1_busy, d1_fe, d1_ov}, {d4_valid, d4_data, d4_busy, d4_fe, d4_ov});
    end
    clear_stim(40);
    put_frame(0, 4, 4'h6, 1'b1);
    run_window(1'b1);
    model(0, 1); model(1, 4);
    for (int di = 0; di < 2; di++)
      for (int c = 0; c < len; c++) begin
        vecs++;
        if (got_pk[di][c] !== exp_pk[di][c]) begin
          miscompares++;
          $display("FAIL reset_mid dut%0d cycle %0d: got %b want %b", di, c, got_pk[di][c], exp_pk[di][c]);
        end
      end
  endtask

  task automatic test_random();
    int pos, n;
    logic [3:0] w;
    for (int win = 0; win < 8; win++) begin
      clear_stim(200);
      pos = $urandom_range(0, 5);
      while (pos < 200 - 40 - 24) begin
        n = ($urandom_range(0, 1) == 0) ? 1 : 4;
        w = 4'($urandom_range(0, 15));
        put_frame(pos, n, w, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
        pos = pos + 6 * n + $urandom_range(0, 6);
      end
      for (int c = 0; c < 200; c++) begin
        s_rdy[c] = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
        if (c < 160 && $urandom_range(0, 40) == 0) s_en[c] = 1'b0;
      end
      run_window(1'b1);
      model(0, 1); model(1, 4);
      for (int di = 0; di < 2; di++)
        for (int c = 0; c < len; c++) begin
          vecs++;
          if (got_pk[di][c] !== exp_pk[di][c]) begin
            miscompares++;
            $display("FAIL random%0d dut%0d cycle %0d: got %b want %b", win, di, c, got_pk[di][c], exp_pk[di][c]);
          end
        end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; serial_in = 1'b1; out_ready = 1'b0;
    test_reset();
    test_frame_n1();
    test_frame_n4();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_enable_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_rx_controller.md
# serial_rx_controller

Frame-level receive controller that sequences a serial-in, right-shift capture register. It detects a start bit on a single-wire input and samples WIDTH data bits, LSB first, at bit-centre. It then checks the stop bit and hands the assembled word downstream over a valid/ready handshake through a one-deep holding register. It sits between the raw serial pin and any word-wide consumer, and reports framing and overrun errors.

## Interface
- WIDTH, 4, data bits per frame (≥1)
- CLKS_PER_BIT, 1, clock cycles per serial bit (≥1); HALF = (CLKS_PER_BIT-1)/2, integer division
- clk  input  1  single clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  receiver enable; low forces IDLE
- serial_in  input  1  serial line (idle high); already synchronous to clk
- data_out  output  WIDTH  holding register contents, valid while out_valid=1
- out_valid  output  1  word available
- out_ready  input  1  consumer accepts word when out_valid & out_ready
- busy  output  1  high whenever FSM is not in IDLE
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full

## Operation
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- Frame bit k: k=0 start, k=1..WIDTH data, k=WIDTH+1 stop. Let t0 = first cycle serial_in is sampled 0 in IDLE with enable=1. Bit k is sampled at cycle t0 + k*CLKS_PER_BIT + HALF.
- IDLE: serial_in=0 & enable → START (bit-period counter cleared).
- START: at start-sample cycle, serial_in=0 → DATA; serial_in=1 → IDLE (false start, no flags).
- DATA: at each data-sample cycle, shift right, sampled bit enters MSB (shreg <= {serial_in, shreg[WIDTH-1:1]}). After WIDTH samples, data bit 1 is in the LSB → STOP.
- STOP: at stop-sample cycle:
  - serial_in=1: word complete → IDLE.
  - serial_in=0: frame_err pulse, word discarded → WAIT_HIGH.
- WAIT_HIGH: stay until serial_in=1 → IDLE. This prevents a stuck-low line from retriggering.
- Holding register, on word complete:
  - out_valid=0: load data_out, set out_valid.
  - out_valid=1 & out_ready=1 same cycle: load new word, out_valid stays 1.
  - out_valid=1 & out_ready=0: overrun pulse, new word dropped, data_out unchanged.
- Accept with no new word: out_valid clears next cycle; data_out retains last value.
- enable=0 in any state: next state IDLE, partial word and counters discarded, no flags. Holding register and handshake are unaffected.
- Counters: bit-period counter sized for CLKS_PER_BIT-1; bit index sized for WIDTH; both wrap only via reload, never free-running.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, shreg 0, data_out 0, out_valid 0, busy 0, frame_err 0, overrun 0.
- Reset mid-frame: immediate return to reset values; held word is lost.
- busy rises the cycle after t0.
- out_valid, frame_err and overrun are registered. They assert in cycle t0 + (WIDTH+1)*CLKS_PER_BIT + HALF + 1.
- The FSM is in IDLE in that same cycle and can accept a new start edge immediately (back-to-back frames).
- No combinational path from serial_in or out_ready to any output.

## Test plan
- WIDTH=4, N=1: serial_in 0,1,0,1,1,1 from t0=0 → data_out=4'hD, out_valid=1 at cycle 6, frame_err=0, busy high cycles 1–5.
- WIDTH=4, N=4 (HALF=1): same frame, each bit held 4 cycles → samples at t0+1,5,9,13,17,21; out_valid at t0+22, data_out=4'hD.
- N=4: serial_in low for 1 cycle then high → START aborts at t0+1, back in IDLE, no out_valid and no flags.
- N=1: frame 0,0,0,0,0,0 then line low 3 more cycles → frame_err pulse at cycle 6, FSM in WAIT_HIGH until serial_in=1, out_valid stays 0.
- N=1, out_ready=0: two back-to-back frames carrying 4'h3 then 4'hA → first held (data_out=4'h3), overrun pulse at second completion, data_out still 4'h3. Repeat with out_ready=1 on second completion cycle → data_out=4'hA, out_valid stays 1, no overrun.
- N=4: drop enable or assert reset_n=0 during DATA → FSM IDLE next cycle (reset: immediately), no out_valid. The following clean frame 4'h6 is received correctly.
